// File: rtl/pipe_pkg.sv
// Shared pipeline types and widths for the fetch path.
// A fetch entry packs {pc, instr} so the queue stores one 64-bit word per instruction.
package pipe_pkg;
  localparam int INSTR_W = 32;
  localparam int PC_W = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of fetch entries sitting between imem read data and IF/ID.
// Flush wins over push; the head is a combinational read of the oldest entry.
module fetch_queue
  import pipe_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t push_data,
  output fetch_entry_t head,
  output logic [AW:0]  count
);

  fetch_entry_t   mem [DEPTH];
  logic [AW-1:0]  rd_ptr;
  logic [AW-1:0]  wr_ptr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end

  // Storage is not reset; count alone decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, registered imem read, and a credit scheme that
// keeps count + in-flight within the queue depth so stalls never drop a fetched word.
module if_fetch_stage
  import pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          IMEM_DEPTH  = 256,
  parameter int          QUEUE_DEPTH = 2,
  parameter string       IMEM_INIT   = ""
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic                redirect_valid,
  input  logic [PC_W-1:0]     redirect_pc,
  output logic                valid_out,
  output logic [INSTR_W-1:0]  instr_out,
  output logic [PC_W-1:0]     pc_out,
  output logic [PC_W-1:0]     pc_plus4_out
);

  localparam int IAW = $clog2(IMEM_DEPTH);
  localparam int QAW = $clog2(QUEUE_DEPTH);
  localparam int CW  = QAW + 2;

  // Contents come from the image loaded by the surrounding environment (IMEM_INIT).
  logic [INSTR_W-1:0] imem [IMEM_DEPTH];

  logic [PC_W-1:0]    fetch_pc;
  logic [PC_W-1:0]    inflight_pc;
  logic [INSTR_W-1:0] imem_q;
  logic               inflight;
  logic [QAW:0]       count;
  fetch_entry_t       head;
  fetch_entry_t       push_data;
  logic               pop;
  logic               push;
  logic [CW-1:0]      credit;
  logic               issue;
  logic [PC_W-1:0]    issue_addr;
  logic               unused_bits;

  assign valid_out = (count != '0);
  assign pop       = valid_out & ~stall;

  // Never negative: count + inflight <= QUEUE_DEPTH holds by construction.
  assign credit = CW'(QUEUE_DEPTH) + CW'(pop) - CW'(count) - CW'(inflight);

  // A redirect flushes everything, so it can always issue regardless of credit.
  assign issue      = redirect_valid | (credit != '0);
  assign issue_addr = redirect_valid ? {redirect_pc[PC_W-1:2], 2'b00} : fetch_pc;

  assign push      = inflight & ~redirect_valid;
  assign push_data = '{pc: inflight_pc, instr: imem_q};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_pc <= issue_addr;
        fetch_pc    <= issue_addr + 32'd4;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (issue) imem_q <= imem[issue_addr[IAW+1:2]];
  end

  fetch_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .flush     (redirect_valid),
    .push_data (push_data),
    .head      (head),
    .count     (count)
  );

  assign instr_out    = valid_out ? head.instr : NOP_INSTR;
  assign pc_out       = valid_out ? head.pc : '0;
  assign pc_plus4_out = valid_out ? head.pc + 32'd4 : '0;

  assign unused_bits = &{1'b0, redirect_pc[1:0], (IMEM_INIT == "")};

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: streaming, stall, redirects, address wrap, async reset.
// imem[i] = A000_0000 + i, so the expected word for any pc is derived from pc[9:2].
module tb_if_fetch_stage;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        valid_out;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4_out;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  if_fetch_stage dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .valid_out      (valid_out),
    .instr_out      (instr_out),
    .pc_out         (pc_out),
    .pc_plus4_out   (pc_plus4_out)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_instr(input logic [31:0] pc);
    return 32'hA000_0000 + {24'h0, pc[9:2]};
  endfunction

  task automatic chk_head(input string tag, input logic [31:0] pc);
    chk({tag, "_valid"}, {31'h0, valid_out}, 32'h1);
    chk({tag, "_pc"}, pc_out, pc);
    chk({tag, "_instr"}, instr_out, model_instr(pc));
    chk({tag, "_pc4"}, pc_plus4_out, pc + 32'd4);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, {31'h0, valid_out}, 32'h0);
    chk({tag, "_pc"}, pc_out, 32'h0);
    chk({tag, "_instr"}, instr_out, 32'h0);
    chk({tag, "_pc4"}, pc_plus4_out, 32'h0);
  endtask

  task automatic redirect(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    tick();
    redirect_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) dut.imem[i] = 32'hA000_0000 + 32'(i);

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk_idle("reset");

    // Release reset: first word valid after the second edge, then one per cycle
    reset = 1'b1;
    tick();
    chk("e1_valid", {31'h0, valid_out}, 32'h0);
    tick();
    chk_head("e2", 32'h0);
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk_head("stream", 32'(4 * k));
    end

    // Stall for 5 cycles: head holds, then contiguous resume
    stall = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk_head("stall_hold", 32'h14);
    end
    stall = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk_head("post_stall", 32'h14 + 32'(4 * k));
    end

    // Redirect to 0x40 while stalled with a full queue
    stall = 1'b1;
    tick();
    tick();
    chk_head("full_hold", 32'h24);
    redirect(32'h0000_0040);
    stall = 1'b0;
    chk("redir_flush_valid", {31'h0, valid_out}, 32'h0);
    tick();
    chk_head("redir40", 32'h40);
    tick();
    chk_head("redir40_next", 32'h44);

    // Misaligned redirect target is aligned down
    redirect(32'h0000_0043);
    chk("redir43_flush_valid", {31'h0, valid_out}, 32'h0);
    tick();
    chk_head("redir43", 32'h40);

    // Back-to-back redirects: only the second target survives
    redirect(32'h0000_0100);
    redirect(32'h0000_0200);
    chk("b2b_flush_valid", {31'h0, valid_out}, 32'h0);
    tick();
    chk_head("b2b_first", 32'h200);
    tick();
    chk_head("b2b_second", 32'h204);

    // imem index wraps past 0x3FC
    redirect(32'h0000_03F8);
    tick();
    chk_head("wrap_3f8", 32'h3F8);
    tick();
    chk_head("wrap_3fc", 32'h3FC);
    tick();
    chk_head("wrap_400", 32'h400);

    // PC wraps mod 2^32
    redirect(32'hFFFF_FFFC);
    tick();
    chk_head("top_pc", 32'hFFFF_FFFC);
    tick();
    chk_head("top_pc_wrap", 32'h0);

    // Asynchronous reset between edges
    @(posedge clk);
    #2 reset = 1'b0;
    #1 chk_idle("async_rst");
    @(negedge clk);
    chk_idle("async_rst_hold");
    reset = 1'b1;
    tick();
    chk("restart_e1_valid", {31'h0, valid_out}, 32'h0);
    tick();
    chk_head("restart_e2", 32'h0);
    tick();
    chk_head("restart_next", 32'h4);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
